// File: rtl/ball_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ball_controller
//  Description : Per-frame ball sequencer: erase, move/reflect, redraw via
//                a request/ready plotter handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_controller #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int PADDLE_Y = 116,
  parameter int PADDLE_W = 16,
  parameter int BALL_X0  = 80,
  parameter int BALL_Y0  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] paddle_x,
  input  logic       draw_ready,
  output logic       draw_req,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic [2:0] draw_colour,
  output logic [7:0] ball_x,
  output logic [6:0] ball_y,
  output logic [1:0] dir,
  output logic       miss,
  output logic       busy
);

  localparam logic [7:0] c_x_max    = 8'(SCREEN_W - 1);
  localparam logic [6:0] c_y_max    = 7'(SCREEN_H - 1);
  localparam logic [6:0] c_pad_row  = 7'(PADDLE_Y - 1);
  localparam logic [8:0] c_pad_span = 9'(PADDLE_W - 1);
  localparam logic [7:0] c_x0       = 8'(BALL_X0);
  localparam logic [6:0] c_y0       = 7'(BALL_Y0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_pending;
  logic       r_draw_req;
  logic [7:0] r_draw_x;
  logic [6:0] r_draw_y;
  logic [2:0] r_colour;
  logic [7:0] r_ball_x;
  logic [6:0] r_ball_y;
  logic [1:0] r_dir;
  logic       r_miss;
  logic       r_busy;

  logic       w_dir_x;
  logic       w_dir_y;
  logic       w_hit;
  logic       w_miss;
  logic [8:0] w_pad_lo;
  logic [8:0] w_pad_hi;
  logic [8:0] w_bx9;
  logic [7:0] w_next_x;
  logic [6:0] w_next_y;

  // Paddle span is compared in 9 bits so a paddle near X=255 cannot wrap.
  always_comb begin
    w_dir_x = r_dir[0];
    if (!r_dir[0] && (r_ball_x == c_x_max))
      w_dir_x = 1'b1;
    else if (r_dir[0] && (r_ball_x == 8'd0))
      w_dir_x = 1'b0;

    w_pad_lo = {1'b0, paddle_x};
    w_pad_hi = w_pad_lo + c_pad_span;
    w_bx9    = {1'b0, r_ball_x};
    w_hit    = !r_dir[1] && (r_ball_y == c_pad_row) &&
               (w_bx9 >= w_pad_lo) && (w_bx9 <= w_pad_hi);

    w_dir_y = r_dir[1];
    if (r_dir[1] && (r_ball_y == 7'd0))
      w_dir_y = 1'b0;
    else if (w_hit)
      w_dir_y = 1'b1;

    w_miss   = !r_dir[1] && (r_ball_y == c_y_max);
    w_next_x = w_dir_x ? (r_ball_x - 8'd1) : (r_ball_x + 8'd1);
    w_next_y = w_dir_y ? (r_ball_y - 7'd1) : (r_ball_y + 7'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_draw_req <= 1'b0;
      r_draw_x   <= 8'd0;
      r_draw_y   <= 7'd0;
      r_colour   <= 3'b000;
      r_ball_x   <= c_x0;
      r_ball_y   <= c_y0;
      r_dir      <= 2'b00;
      r_miss     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_tick || r_pending) begin
            r_pending  <= 1'b0;
            r_state    <= ST_ERASE;
            r_busy     <= 1'b1;
            r_draw_req <= 1'b1;
            r_draw_x   <= r_ball_x;
            r_draw_y   <= r_ball_y;
            r_colour   <= 3'b000;
          end
        end
        ST_ERASE: begin
          if (frame_tick) r_pending <= 1'b1;
          if (draw_ready) begin
            r_draw_req <= 1'b0;
            r_state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (frame_tick) r_pending <= 1'b1;
          r_state    <= ST_DRAW;
          r_draw_req <= 1'b1;
          r_colour   <= 3'b111;
          if (w_miss) begin
            r_ball_x <= c_x0;
            r_ball_y <= c_y0;
            r_dir    <= 2'b00;
            r_miss   <= 1'b1;
            r_draw_x <= c_x0;
            r_draw_y <= c_y0;
          end else begin
            r_ball_x <= w_next_x;
            r_ball_y <= w_next_y;
            r_dir    <= {w_dir_y, w_dir_x};
            r_draw_x <= w_next_x;
            r_draw_y <= w_next_y;
          end
        end
        ST_DRAW: begin
          if (frame_tick) r_pending <= 1'b1;
          if (draw_ready) begin
            r_draw_req <= 1'b0;
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign draw_req    = r_draw_req;
  assign draw_x      = r_draw_x;
  assign draw_y      = r_draw_y;
  assign draw_colour = r_colour;
  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign dir         = r_dir;
  assign miss        = r_miss;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ball_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_controller
//  Description : Directed self-checking bench for ball_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_controller;

  logic       clk;
  logic       reset;
  logic       tick, tick_c;
  logic [7:0] paddle_x, paddle_x_c;
  logic       draw_ready;

  logic       draw_req, draw_req_c;
  logic [7:0] draw_x, draw_x_c;
  logic [6:0] draw_y, draw_y_c;
  logic [2:0] draw_colour, draw_colour_c;
  logic [7:0] ball_x, ball_x_c;
  logic [6:0] ball_y, ball_y_c;
  logic [1:0] dir, dir_c;
  logic       miss, miss_c;
  logic       busy, busy_c;

  int n_cmp  = 0;
  int n_fail = 0;
  int miss_seen;
  int last_dx, last_dy;
  int cnt;

  ball_controller dut (
    .clk(clk), .reset(reset), .frame_tick(tick), .paddle_x(paddle_x),
    .draw_ready(draw_ready), .draw_req(draw_req), .draw_x(draw_x),
    .draw_y(draw_y), .draw_colour(draw_colour), .ball_x(ball_x),
    .ball_y(ball_y), .dir(dir), .miss(miss), .busy(busy)
  );

  // Second instance respawns near the bottom-right corner so the
  // wall+paddle double reflection is reachable in a few steps.
  ball_controller #(.BALL_X0(150), .BALL_Y0(106)) dut_c (
    .clk(clk), .reset(reset), .frame_tick(tick_c), .paddle_x(paddle_x_c),
    .draw_ready(draw_ready), .draw_req(draw_req_c), .draw_x(draw_x_c),
    .draw_y(draw_y_c), .draw_colour(draw_colour_c), .ball_x(ball_x_c),
    .ball_y(ball_y_c), .dir(dir_c), .miss(miss_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ball(input string tag, input bit sel,
                          input int x, input int y, input int d);
    chk({tag, "_x"},   sel ? ball_x_c : ball_x, x);
    chk({tag, "_y"},   sel ? ball_y_c : ball_y, y);
    chk({tag, "_dir"}, sel ? dir_c : dir, d);
  endtask

  // One tick, then wait (bounded) for the step to finish.
  task automatic step(input bit sel);
    int c;
    if (sel) tick_c = 1'b1; else tick = 1'b1;
    cyc();
    tick   = 1'b0;
    tick_c = 1'b0;
    c = 0;
    while ((sel ? busy_c : busy) && c < 20) begin
      if (sel ? miss_c : miss) miss_seen++;
      if ((sel ? draw_req_c : draw_req) && (sel ? draw_colour_c : draw_colour) == 3'b111) begin
        last_dx = sel ? draw_x_c : draw_x;
        last_dy = sel ? draw_y_c : draw_y;
      end
      cyc();
      c++;
    end
    chk("step_done", sel ? busy_c : busy, 0);
  endtask

  task automatic run_steps(input bit sel, input int n);
    for (int i = 0; i < n; i++) step(sel);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; tick_c = 1'b0;
    paddle_x = 8'd120; paddle_x_c = 8'd150; draw_ready = 1'b1;
    miss_seen = 0; last_dx = 0; last_dy = 0;
    cyc(); cyc();
    reset = 1'b0;

    chk_ball("rst", 0, 80, 60, 0);
    chk("rst_req", draw_req, 0);
    chk("rst_dx", draw_x, 0);
    chk("rst_dy", draw_y, 0);
    chk("rst_col", draw_colour, 0);
    chk("rst_miss", miss, 0);
    chk("rst_busy", busy, 0);
    chk_ball("rst_c", 1, 150, 106, 0);

    // Straight step, cycle by cycle
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("n1_req", draw_req, 1);
    chk("n1_dx", draw_x, 80);
    chk("n1_dy", draw_y, 60);
    chk("n1_col", draw_colour, 0);
    chk("n1_busy", busy, 1);
    cyc();
    chk("n2_req", draw_req, 0);
    chk("n2_busy", busy, 1);
    chk_ball("n2", 0, 80, 60, 0);
    cyc();
    chk("n3_req", draw_req, 1);
    chk("n3_dx", draw_x, 81);
    chk("n3_dy", draw_y, 61);
    chk("n3_col", draw_colour, 7);
    chk("n3_busy", busy, 1);
    chk("n3_miss", miss, 0);
    chk_ball("n3", 0, 81, 61, 0);
    cyc();
    chk("n4_req", draw_req, 0);
    chk("n4_busy", busy, 0);

    // Paddle hit on its right-most pixel (120..135), then right wall
    run_steps(0, 54);
    chk_ball("pre_hit", 0, 135, 115, 0);
    step(0);
    chk_ball("hit", 0, 136, 114, 2);
    run_steps(0, 23);
    chk_ball("pre_wall", 0, 159, 91, 2);
    step(0);
    chk_ball("wall", 0, 158, 90, 3);

    // Paddle one pixel to the right of the ball: pass, then miss
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_ball("rst2", 0, 80, 60, 0);
    paddle_x = 8'd136;
    run_steps(0, 55);
    miss_seen = 0;
    step(0);
    chk_ball("pass", 0, 136, 116, 0);
    run_steps(0, 3);
    chk_ball("pre_miss", 0, 139, 119, 0);
    chk("pre_miss_cnt", miss_seen, 0);
    step(0);
    chk("miss_cnt", miss_seen, 1);
    chk_ball("respawn", 0, 80, 60, 0);
    chk("respawn_dx", last_dx, 80);
    chk("respawn_dy", last_dy, 60);

    // Stall in ERASE with three ticks while busy
    draw_ready = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("stall_req", draw_req, 1);
    for (int i = 0; i < 5; i++) begin
      tick = (i % 2 == 0);
      cyc();
      tick = 1'b0;
      chk("stall_req", draw_req, 1);
      chk("stall_dx", draw_x, 80);
      chk("stall_dy", draw_y, 60);
      chk("stall_col", draw_colour, 0);
    end
    draw_ready = 1'b1;
    cnt = 0;
    while (busy && cnt < 20) begin cyc(); cnt++; end
    chk("stall_idle", busy, 0);
    chk_ball("stall_step", 0, 81, 61, 0);
    cnt = 0;
    while (!busy && cnt < 5) begin cyc(); cnt++; end
    chk("pend_start", busy, 1);
    cnt = 0;
    while (busy && cnt < 20) begin cyc(); cnt++; end
    chk_ball("pend_step", 0, 82, 62, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) cnt++;
      cyc();
    end
    chk("no_extra_step", cnt, 0);
    chk_ball("after_pend", 0, 82, 62, 0);

    // Reset while DRAW is stalled, with a pending tick queued
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    draw_ready = 1'b0;
    tick = 1'b1;
    chk("md_req", draw_req, 1);
    chk("md_col", draw_colour, 7);
    chk_ball("md", 0, 83, 63, 0);
    cyc();
    tick = 1'b0;
    reset = 1'b1;
    chk("md_hold", draw_req, 1);
    cyc();
    reset = 1'b0;
    chk("mr_req", draw_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_dx", draw_x, 0);
    chk("mr_miss", miss, 0);
    chk_ball("mr", 0, 80, 60, 0);
    draw_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) cnt++;
      cyc();
    end
    chk("mr_no_pending", cnt, 0);

    // Corner: right wall and paddle hit together, then top and left walls
    chk_ball("c_start", 1, 150, 106, 0);
    run_steps(1, 9);
    chk_ball("c_pre", 1, 159, 115, 0);
    step(1);
    chk_ball("corner", 1, 158, 114, 3);
    run_steps(1, 114);
    chk_ball("c_pre_top", 1, 44, 0, 3);
    step(1);
    chk_ball("c_top", 1, 43, 1, 1);
    run_steps(1, 43);
    chk_ball("c_pre_left", 1, 0, 44, 1);
    step(1);
    chk_ball("c_left", 1, 1, 45, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
